riscy_seq_ctrl: RTL and testbench



---
 rtl/riscy_seq_ctrl.sv | 155 +++++++++++++++
 tb/tb_riscy_seq_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/riscy_seq_ctrl.sv
// RISC-Y sequence controller: state-decoded control strobes, memory wait states,
// indirect pointer fetch and halt. Define RISCY_SINGLE_STEP_EN to add the STEP input.
module riscy_seq_ctrl #(
  parameter int unsigned WAIT_STATES = 0,
  parameter bit          INDIRECT    = 1'b1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [2:0] OPCODE,
  input  logic       I_FLAG,
  input  logic       ZERO,
`ifdef RISCY_SINGLE_STEP_EN
  input  logic       STEP,
`endif
  output logic       sel,
  output logic       rd,
  output logic       wr,
  output logic       ld_ir,
  output logic       ld_ptr,
  output logic       ld_ac,
  output logic       ld_pc,
  output logic       inc_pc,
  output logic       data_e,
  output logic       halt,
  output logic [3:0] phase
);

  typedef enum logic [3:0] {
    S_IADDR  = 4'd0,
    S_IFETCH = 4'd1,
    S_ILOAD  = 4'd2,
    S_IDLE   = 4'd3,
    S_OADDR  = 4'd4,
    S_PADDR  = 4'd5,
    S_PFETCH = 4'd6,
    S_PLOAD  = 4'd7,
    S_OFETCH = 4'd8,
    S_ALU    = 4'd9,
    S_STORE  = 4'd10,
    S_HALT   = 4'd15
  } state_t;

  typedef enum logic [2:0] {
    OP_HLT = 3'd0,
    OP_SKZ = 3'd1,
    OP_ADD = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_LDA = 3'd5,
    OP_STO = 3'd6,
    OP_JMP = 3'd7
  } opcode_t;

  localparam int unsigned   CW    = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CW-1:0] W_MAX = CW'(WAIT_STATES);

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  opcode_t       w_op;
  logic          w_mem_rd_op;
  logic          w_is_wait;
  logic          w_wait_done;
  logic          w_go_indirect;
  logic          w_advance;

  assign w_op          = opcode_t'(OPCODE);
  assign w_mem_rd_op   = (w_op inside {OP_ADD, OP_AND, OP_XOR, OP_LDA});
  assign w_is_wait     = (r_state inside {S_IFETCH, S_PFETCH, S_OFETCH});
  assign w_wait_done   = (r_cnt == W_MAX);
  assign w_go_indirect = INDIRECT && I_FLAG && (w_op inside {OP_ADD, OP_AND, OP_XOR,
                                                             OP_LDA, OP_STO, OP_JMP});

`ifdef RISCY_SINGLE_STEP_EN
  assign w_advance = STEP;
`else
  assign w_advance = 1'b1;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IADDR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      // Counter only runs inside a wait-capable state and clears on its exit.
      r_cnt   <= (w_is_wait && !w_wait_done) ? r_cnt + CW'(1) : '0;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IADDR:  if (w_advance) w_next = S_IFETCH;
      S_IFETCH: if (w_wait_done) w_next = S_ILOAD;
      S_ILOAD:  w_next = S_IDLE;
      S_IDLE:   w_next = S_OADDR;
      S_OADDR: begin
        if (w_op == OP_HLT)     w_next = S_HALT;
        else if (w_go_indirect) w_next = S_PADDR;
        else                    w_next = S_OFETCH;
      end
      S_PADDR:  w_next = S_PFETCH;
      S_PFETCH: if (w_wait_done) w_next = S_PLOAD;
      S_PLOAD:  w_next = S_OFETCH;
      S_OFETCH: if (w_wait_done) w_next = S_ALU;
      S_ALU:    w_next = S_STORE;
      S_STORE:  w_next = S_IADDR;
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_IADDR;
    endcase
  end

  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    wr     = 1'b0;
    ld_ir  = 1'b0;
    ld_ptr = 1'b0;
    ld_ac  = 1'b0;
    ld_pc  = 1'b0;
    inc_pc = 1'b0;
    data_e = 1'b0;
    halt   = 1'b0;
    phase  = r_state;
    unique case (r_state)
      S_IADDR:  sel = 1'b1;
      S_IFETCH: begin sel = 1'b1; rd = 1'b1; end
      S_ILOAD:  begin sel = 1'b1; rd = 1'b1; ld_ir = 1'b1; end
      S_IDLE:   begin sel = 1'b1; rd = 1'b1; end
      S_OADDR: begin
        inc_pc = 1'b1;
        halt   = (w_op == OP_HLT);
      end
      S_PADDR:  ;
      S_PFETCH: rd = 1'b1;
      S_PLOAD:  begin rd = 1'b1; ld_ptr = 1'b1; end
      S_OFETCH: rd = w_mem_rd_op;
      S_ALU: begin
        rd     = w_mem_rd_op;
        ld_ac  = w_mem_rd_op;
        inc_pc = (w_op == OP_SKZ) && ZERO;
        ld_pc  = (w_op == OP_JMP);
        data_e = (w_op == OP_STO);
      end
      S_STORE: begin
        wr     = (w_op == OP_STO);
        data_e = (w_op == OP_STO);
      end
      S_HALT:   halt = 1'b1;
      default:  ;
    endcase
  end

endmodule

// File: tb/tb_riscy_seq_ctrl.sv
// Directed bench for riscy_seq_ctrl: four instances with different WAIT_STATES/INDIRECT
// settings share stimulus; per-cycle table vectors plus hand sequences for reset/halt.
module tb_riscy_seq_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [2:0] OPCODE = 3'd0;
  logic       I_FLAG = 1'b0;
  logic       ZERO = 1'b0;
`ifdef RISCY_SINGLE_STEP_EN
  logic       STEP = 1'b1;
`endif

  always #5 CLK = ~CLK;

  // Packed {phase, sel, rd, wr, ld_ir, ld_ptr, ld_ac, ld_pc, inc_pc, data_e, halt}
  logic [13:0] w_out [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int unsigned WS  = (g == 1) ? 2 : (g == 3) ? 3 : 0;
    localparam bit          IND = (g == 2) ? 1'b0 : 1'b1;
    logic       sel, rd, wr, ld_ir, ld_ptr, ld_ac, ld_pc, inc_pc, data_e, halt;
    logic [3:0] phase;
    riscy_seq_ctrl #(.WAIT_STATES(WS), .INDIRECT(IND)) u_dut (
      .CLK(CLK), .RST(RST), .OPCODE(OPCODE), .I_FLAG(I_FLAG), .ZERO(ZERO),
`ifdef RISCY_SINGLE_STEP_EN
      .STEP(STEP),
`endif
      .sel(sel), .rd(rd), .wr(wr), .ld_ir(ld_ir), .ld_ptr(ld_ptr), .ld_ac(ld_ac),
      .ld_pc(ld_pc), .inc_pc(inc_pc), .data_e(data_e), .halt(halt), .phase(phase)
    );
    assign w_out[g] = {phase, sel, rd, wr, ld_ir, ld_ptr, ld_ac, ld_pc, inc_pc, data_e, halt};
  end

  localparam logic [9:0] S_SEL = 10'b1000000000, S_RD  = 10'b0100000000,
                         S_WR  = 10'b0010000000, S_IR  = 10'b0001000000,
                         S_PTR = 10'b0000100000, S_AC  = 10'b0000010000,
                         S_PC  = 10'b0000001000, S_INC = 10'b0000000100,
                         S_DE  = 10'b0000000010, S_HLT = 10'b0000000001,
                         S_NONE = 10'b0;

  typedef struct {
    int         dut;
    bit         rst;
    logic [2:0] op;
    logic       iflag;
    logic       zero;
    logic [3:0] ph;
    logic [9:0] st;
  } vec_t;

  vec_t tv[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic add(input int d, input bit r, input logic [2:0] op, input logic f,
                     input logic z, input logic [3:0] ph, input logic [9:0] st);
    vec_t v;
    v.dut = d; v.rst = r; v.op = op; v.iflag = f; v.zero = z; v.ph = ph; v.st = st;
    tv.push_back(v);
  endtask

  task automatic chk(input string name, input logic [13:0] got, input logic [13:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got phase=%0d strobes=%b, expected phase=%0d strobes=%b",
               name, got[13:10], got[9:0], exp[13:10], exp[9:0]);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  // Common instruction-fetch prefix for W=0 instances: IADDR..OADDR.
  task automatic add_fetch0(input int d, input logic [2:0] op, input logic f, input logic z);
    add(d, 1, op, f, z, 4'd0, S_SEL);
    add(d, 0, op, f, z, 4'd1, S_SEL | S_RD);
    add(d, 0, op, f, z, 4'd2, S_SEL | S_RD | S_IR);
    add(d, 0, op, f, z, 4'd3, S_SEL | S_RD);
    add(d, 0, op, f, z, 4'd4, (op == 3'd0) ? (S_INC | S_HLT) : S_INC);
  endtask

  initial begin
    // LDA direct, W=0: 8-cycle instruction then back to IADDR
    add_fetch0(0, 3'd5, 0, 0);
    add(0, 0, 3'd5, 0, 0, 4'd8,  S_RD);
    add(0, 0, 3'd5, 0, 0, 4'd9,  S_RD | S_AC);
    add(0, 0, 3'd5, 0, 0, 4'd10, S_NONE);
    add(0, 0, 3'd5, 0, 0, 4'd0,  S_SEL);
    // LDA direct, W=2: IFETCH and OFETCH held 3 cycles each
    add(1, 1, 3'd5, 0, 0, 4'd0, S_SEL);
    for (int i = 0; i < 3; i++) add(1, 0, 3'd5, 0, 0, 4'd1, S_SEL | S_RD);
    add(1, 0, 3'd5, 0, 0, 4'd2, S_SEL | S_RD | S_IR);
    add(1, 0, 3'd5, 0, 0, 4'd3, S_SEL | S_RD);
    add(1, 0, 3'd5, 0, 0, 4'd4, S_INC);
    for (int i = 0; i < 3; i++) add(1, 0, 3'd5, 0, 0, 4'd8, S_RD);
    add(1, 0, 3'd5, 0, 0, 4'd9,  S_RD | S_AC);
    add(1, 0, 3'd5, 0, 0, 4'd10, S_NONE);
    add(1, 0, 3'd5, 0, 0, 4'd0,  S_SEL);
    // STO indirect, W=0, INDIRECT=1: pointer phases inserted
    add_fetch0(0, 3'd6, 1, 0);
    add(0, 0, 3'd6, 1, 0, 4'd5,  S_NONE);
    add(0, 0, 3'd6, 1, 0, 4'd6,  S_RD);
    add(0, 0, 3'd6, 1, 0, 4'd7,  S_RD | S_PTR);
    add(0, 0, 3'd6, 1, 0, 4'd8,  S_NONE);
    add(0, 0, 3'd6, 1, 0, 4'd9,  S_DE);
    add(0, 0, 3'd6, 1, 0, 4'd10, S_WR | S_DE);
    add(0, 0, 3'd6, 1, 0, 4'd0,  S_SEL);
    // STO with I_FLAG=1 on INDIRECT=0 instance: direct path
    add_fetch0(2, 3'd6, 1, 0);
    add(2, 0, 3'd6, 1, 0, 4'd8,  S_NONE);
    add(2, 0, 3'd6, 1, 0, 4'd9,  S_DE);
    add(2, 0, 3'd6, 1, 0, 4'd10, S_WR | S_DE);
    add(2, 0, 3'd6, 1, 0, 4'd0,  S_SEL);
    // SKZ ZERO=1 with I_FLAG=1 (ignored): second inc_pc in ALU
    add_fetch0(0, 3'd1, 1, 1);
    add(0, 0, 3'd1, 1, 1, 4'd8,  S_NONE);
    add(0, 0, 3'd1, 1, 1, 4'd9,  S_INC);
    add(0, 0, 3'd1, 1, 1, 4'd10, S_NONE);
    // SKZ ZERO=0: no inc_pc in ALU
    add_fetch0(0, 3'd1, 0, 0);
    add(0, 0, 3'd1, 0, 0, 4'd8,  S_NONE);
    add(0, 0, 3'd1, 0, 0, 4'd9,  S_NONE);
    add(0, 0, 3'd1, 0, 0, 4'd10, S_NONE);
    // JMP direct
    add_fetch0(0, 3'd7, 0, 0);
    add(0, 0, 3'd7, 0, 0, 4'd8,  S_NONE);
    add(0, 0, 3'd7, 0, 0, 4'd9,  S_PC);
    add(0, 0, 3'd7, 0, 0, 4'd10, S_NONE);
    // ADD indirect on W=2: 11+3*2 = 17 cycles
    add(1, 1, 3'd2, 1, 0, 4'd0, S_SEL);
    for (int i = 0; i < 3; i++) add(1, 0, 3'd2, 1, 0, 4'd1, S_SEL | S_RD);
    add(1, 0, 3'd2, 1, 0, 4'd2, S_SEL | S_RD | S_IR);
    add(1, 0, 3'd2, 1, 0, 4'd3, S_SEL | S_RD);
    add(1, 0, 3'd2, 1, 0, 4'd4, S_INC);
    add(1, 0, 3'd2, 1, 0, 4'd5, S_NONE);
    for (int i = 0; i < 3; i++) add(1, 0, 3'd2, 1, 0, 4'd6, S_RD);
    add(1, 0, 3'd2, 1, 0, 4'd7, S_RD | S_PTR);
    for (int i = 0; i < 3; i++) add(1, 0, 3'd2, 1, 0, 4'd8, S_RD);
    add(1, 0, 3'd2, 1, 0, 4'd9,  S_RD | S_AC);
    add(1, 0, 3'd2, 1, 0, 4'd10, S_NONE);
    add(1, 0, 3'd2, 1, 0, 4'd0,  S_SEL);
    // HLT: halt in OADDR, then HALT state
    add_fetch0(0, 3'd0, 1, 0);
    add(0, 0, 3'd0, 1, 0, 4'd15, S_HLT);

    foreach (tv[k]) begin
      if (tv[k].rst) do_reset();
      OPCODE = tv[k].op;
      I_FLAG = tv[k].iflag;
      ZERO   = tv[k].zero;
      #1;
      chk($sformatf("vec%0d_dut%0d", k, tv[k].dut), w_out[tv[k].dut], {tv[k].ph, tv[k].st});
      @(negedge CLK);
    end

    // HALT is absorbing (continuing from the HLT vectors on instance 0)
    for (int i = 0; i < 20; i++) begin
      chk("halt_hold", w_out[0], {4'd15, S_HLT});
      @(negedge CLK);
    end
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("halt_reset", w_out[0], {4'd0, S_SEL});

    // Reset mid-OFETCH on W=3, then the next IFETCH must still last 4 cycles
    do_reset();
    OPCODE = 3'd5;
    I_FLAG = 1'b0;
    repeat (9) @(negedge CLK);
    chk("w3_in_ofetch", w_out[3], {4'd8, S_RD});
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("w3_reset", w_out[3], {4'd0, S_SEL});
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("w3_ifetch", w_out[3], {4'd1, S_SEL | S_RD});
    end
    @(negedge CLK);
    chk("w3_iload", w_out[3], {4'd2, S_SEL | S_RD | S_IR});

`ifdef RISCY_SINGLE_STEP_EN
    STEP = 1'b0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      chk("step_hold", w_out[0], {4'd0, S_SEL});
      @(negedge CLK);
    end
    STEP = 1'b1;
    @(negedge CLK);
    STEP = 1'b0;
    chk("step_ifetch", w_out[0], {4'd1, S_SEL | S_RD});
    repeat (6) @(negedge CLK);
    chk("step_store", w_out[0], {4'd10, S_NONE});
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("step_rehold", w_out[0], {4'd0, S_SEL});
    end
    STEP = 1'b1;
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
